// File: rtl/bcd_to_binary_seq_if.sv
// Start/busy/done handshake bundle for the sequential BCD-to-binary converter.
// The requester drives start/bcd; the converter returns busy/done/err/bin.
interface bcd_to_binary_seq_if #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [BIN_W-1:0]      bin;

    modport master (
        output start, bcd,
        input  busy, done, err, bin
    );

    modport slave (
        input  start, bcd,
        output busy, done, err, bin
    );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble: shift right, then
// subtract 3 from every BCD nibble that is >= 8). One bit per cycle, 4*DIGITS steps.
module bcd_to_binary_seq #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
) (
    input logic               Clk,
    input logic               rst_n,
    bcd_to_binary_seq_if.slave bus
);
    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [2*W-1:0]   work_q, work_d;
    logic [CW-1:0]    count_q, count_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic             err_q, err_d;

    logic             digit_bad;
    logic [2*W-1:0]   work_step;

    always_comb begin
        digit_bad = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bus.bcd[4*i +: 4] > 4'd9) digit_bad = 1'b1;
        end
    end

    // Upper half holds the BCD digits still to be drained; a nibble >= 8 has its top bit set.
    always_comb begin
        work_step = work_q >> 1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (work_step[W + 4*i + 3]) begin
                work_step[W + 4*i +: 4] = work_step[W + 4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        bin_d   = bin_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (digit_bad) begin
                        bin_d   = '0;
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        work_d  = {bus.bcd, {W{1'b0}}};
                        count_d = '0;
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                work_d  = work_step;
                count_d = count_q + 1'b1;
                if (count_q == CW'(W - 1)) begin
                    bin_d   = work_step[BIN_W-1:0];
                    err_d   = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            work_q  <= '0;
            count_q <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.done = (state_q == StDone);
    assign bus.err  = err_q;
    assign bus.bin  = bin_q;
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed scenarios plus a shuffled sweep of
// every valid 3-digit operand against an arithmetic reference model.
module tb_bcd_to_binary_seq;
    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;
    localparam int VALID_N = 4 * DIGITS + 1;  // cycles after accept edge until done is seen

    logic Clk;
    logic rst_n;
    int   total;
    int   bad;

    bcd_to_binary_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .Clk   (Clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference: weighted digit sum; err and zero result on any non-decimal digit.
    function automatic void ref_model(input logic [11:0] v, output int val, output bit e);
        int d;
        val = 0;
        e   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) e = 1'b1;
            val += d * (10 ** i);
        end
        if (e) val = 0;
    endfunction

    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    // Pulses start for one cycle; n counts cycles after the accepting edge (-1 = timeout).
    task automatic run_conv(input logic [11:0] v, output int n_done, output int busy_cyc);
        n_done   = -1;
        busy_cyc = 0;
        @(negedge Clk);
        bus.start = 1'b1;
        bus.bcd   = v;
        @(negedge Clk);
        bus.start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                n_done = n;
                break;
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.bcd   = 12'h999;
        repeat (3) @(negedge Clk);
        total++;
        if ({bus.busy, bus.done, bus.err, bus.bin} !== 13'd0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b bin=%0d, want all 0",
                     bus.busy, bus.done, bus.err, bus.bin);
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(negedge Clk);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got busy=%b, want 0", bus.busy);
        end
    endtask

    task automatic test_max();
        int n, b;
        run_conv(12'h999, n, b);
        total++;
        if (n !== VALID_N) begin
            bad++;
            $display("FAIL max_latency: got done at cycle %0d, want %0d", n, VALID_N);
        end
        total++;
        if (bus.bin !== 10'd999 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL max_value: got bin=%0d err=%b, want 999 err=0", bus.bin, bus.err);
        end
        total++;
        if (b !== VALID_N) begin
            bad++;
            $display("FAIL max_busy: got busy for %0d cycles, want %0d", b, VALID_N);
        end
        @(negedge Clk);
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: got done=%b busy=%b after done, want 0 0",
                     bus.done, bus.busy);
        end
    endtask

    task automatic test_values();
        logic [11:0] vals [4];
        int n, b, exp_v;
        bit exp_e;
        vals = '{12'h000, 12'h105, 12'h010, 12'h898};
        foreach (vals[i]) begin
            ref_model(vals[i], exp_v, exp_e);
            run_conv(vals[i], n, b);
            total++;
            if (n !== VALID_N || int'(bus.bin) !== exp_v || bus.err !== exp_e) begin
                bad++;
                $display("FAIL value_%h: got n=%0d bin=%0d err=%b, want n=%0d bin=%0d err=%b",
                         vals[i], n, bus.bin, bus.err, VALID_N, exp_v, exp_e);
            end
        end
    endtask

    task automatic test_invalid();
        int n, b, exp_v;
        bit exp_e;
        logic [11:0] v;
        run_conv(12'h1A3, n, b);
        total++;
        if (n !== 1 || bus.err !== 1'b1 || bus.bin !== 10'd0) begin
            bad++;
            $display("FAIL invalid_1a3: got n=%0d err=%b bin=%0d, want n=1 err=1 bin=0",
                     n, bus.err, bus.bin);
        end
        @(negedge Clk);
        total++;
        if (bus.err !== 1'b1) begin
            bad++;
            $display("FAIL err_hold: got err=%b, want 1", bus.err);
        end
        run_conv(12'h042, n, b);
        total++;
        if (n !== VALID_N || bus.bin !== 10'd42 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL after_invalid: got n=%0d bin=%0d err=%b, want n=%0d bin=42 err=0",
                     n, bus.bin, bus.err, VALID_N);
        end
        for (int k = 0; k < 6; k++) begin
            v = 12'($urandom);
            v[4*$urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
            ref_model(v, exp_v, exp_e);
            run_conv(v, n, b);
            total++;
            if (n !== (exp_e ? 1 : VALID_N) || bus.err !== exp_e || int'(bus.bin) !== exp_v) begin
                bad++;
                $display("FAIL invalid_rand_%h: got n=%0d err=%b bin=%0d, want err=%b bin=%0d",
                         v, n, bus.err, bus.bin, exp_e, exp_v);
            end
        end
    endtask

    task automatic test_start_held();
        int dones, n_done;
        bit busy_ok;
        dones   = 0;
        n_done  = -1;
        busy_ok = 1'b1;
        @(negedge Clk);
        bus.start = 1'b1;
        bus.bcd   = 12'h500;
        @(negedge Clk);
        for (int n = 1; n <= VALID_N; n++) begin
            if (n == 3) bus.bcd = 12'h777;
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.done) begin
                dones++;
                n_done = n;
            end
            @(negedge Clk);
        end
        total++;
        if (dones !== 1 || n_done !== VALID_N || bus.bin !== 10'd500 || !busy_ok) begin
            bad++;
            $display("FAIL held_start: got dones=%0d at %0d bin=%0d busy_ok=%b, want 1 at %0d 500 1",
                     dones, n_done, bus.bin, busy_ok, VALID_N);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL held_idle_gap: got busy=%b one cycle after done, want 0", bus.busy);
        end
        @(negedge Clk);
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL held_restart: got busy=%b, want 1", bus.busy);
        end
        n_done = -1;
        for (int n = 2; n <= 40; n++) begin
            @(negedge Clk);
            if (bus.done) begin
                n_done = n;
                break;
            end
        end
        total++;
        if (n_done !== VALID_N || bus.bin !== 10'd777) begin
            bad++;
            $display("FAIL held_second: got done at %0d bin=%0d, want %0d 777",
                     n_done, bus.bin, VALID_N);
        end
    endtask

    task automatic test_reset_abort();
        int n, b, dones;
        dones = 0;
        @(negedge Clk);
        bus.start = 1'b1;
        bus.bcd   = 12'h321;
        @(negedge Clk);
        bus.start = 1'b0;
        repeat (4) @(negedge Clk);
        rst_n = 1'b0;
        @(negedge Clk);
        total++;
        if ({bus.busy, bus.done, bus.err, bus.bin} !== 13'd0) begin
            bad++;
            $display("FAIL abort_outputs: got busy=%b done=%b err=%b bin=%0d, want all 0",
                     bus.busy, bus.done, bus.err, bus.bin);
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge Clk);
            if (bus.done) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL abort_no_done: got %0d done pulses, want 0", dones);
        end
        run_conv(12'h321, n, b);
        total++;
        if (n !== VALID_N || bus.bin !== 10'd321) begin
            bad++;
            $display("FAIL abort_recover: got n=%0d bin=%0d, want %0d 321", n, bus.bin, VALID_N);
        end
    endtask

    task automatic test_sweep();
        int ops [1000];
        int j, tmp, n, b, exp_v, prev;
        bit exp_e;
        for (int i = 0; i < 1000; i++) ops[i] = i;
        for (int i = 999; i > 0; i--) begin
            j       = int'($urandom_range(0, i));
            tmp     = ops[i];
            ops[i]  = ops[j];
            ops[j]  = tmp;
        end
        prev = int'(bus.bin);
        for (int i = 0; i < 1000; i++) begin
            @(negedge Clk);
            total++;
            if (int'(bus.bin) !== prev) begin
                bad++;
                $display("FAIL sweep_hold_%0d: got bin=%0d between dones, want %0d",
                         i, bus.bin, prev);
            end
            ref_model(to_bcd(ops[i]), exp_v, exp_e);
            run_conv(to_bcd(ops[i]), n, b);
            total++;
            if (n !== VALID_N || int'(bus.bin) !== exp_v || bus.err !== exp_e) begin
                bad++;
                $display("FAIL sweep_%0d: got n=%0d bin=%0d err=%b, want n=%0d bin=%0d err=%b",
                         ops[i], n, bus.bin, bus.err, VALID_N, exp_v, exp_e);
            end
            prev = exp_v;
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.bcd   = '0;
        test_reset();
        test_max();
        test_values();
        test_invalid();
        test_start_held();
        test_reset_abort();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
